alu_arbiter: RTL

//  Shares one combinational alu (in1/in2/control -> out/zero/neg) among N_REQ requesters.

---
 rtl/alu_arb_pkg.sv | 19 +
 rtl/alu_arbiter_alu.sv | 36 +++
 rtl/alu_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// Shared constants for the alu arbiter: FSM state encodings, stat counter width,
// and the alu control encodings used by both the arbiter's clients and the alu.
package alu_arb_pkg;

    localparam int STAT_W = 16;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t EXEC = 2'd1;
    localparam state_t RESP = 2'd2;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational alu: in1/in2/ctrl -> out plus zero/neg flags taken from the result.
// Unknown control codes produce zero.
module alu_arbiter_alu
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic [DATA_W-1:0] i_in1,
    input  logic [DATA_W-1:0] i_in2,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic [DATA_W-1:0] o_out,
    output logic              o_zero,
    output logic              o_neg
);

    logic [DATA_W-1:0] w_res;

    always_comb begin
        w_res = '0;
        case (i_ctrl)
            CTRL_W'(ALU_AND): w_res = i_in1 & i_in2;
            CTRL_W'(ALU_OR):  w_res = i_in1 | i_in2;
            CTRL_W'(ALU_ADD): w_res = i_in1 + i_in2;
            CTRL_W'(ALU_SUB): w_res = i_in1 - i_in2;
            CTRL_W'(ALU_SLT): w_res = {{(DATA_W-1){1'b0}}, ($signed(i_in1) < $signed(i_in2))};
            CTRL_W'(ALU_NOR): w_res = ~(i_in1 | i_in2);
            default:          w_res = '0;
        endcase
    end

    assign o_out  = w_res;
    assign o_zero = (w_res == '0);
    assign o_neg  = w_res[DATA_W-1];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu among N_REQ requesters; IDLE -> EXEC -> RESP.
// Define ALU_ARB_STATS_EN to add per-requester 16-bit grant counters on o_stat_grants.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int ID_W   = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req_valid,
    output logic [N_REQ-1:0]        o_req_ready,
    input  logic [N_REQ*DATA_W-1:0] i_req_in1,
    input  logic [N_REQ*DATA_W-1:0] i_req_in2,
    input  logic [N_REQ*CTRL_W-1:0] i_req_ctrl,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [ID_W-1:0]         o_rsp_id,
    output logic [DATA_W-1:0]       o_rsp_out,
    output logic                    o_rsp_zero,
    output logic                    o_rsp_neg
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [N_REQ*STAT_W-1:0] o_stat_grants
`endif
);

    // Rotate the valid vector so the search always starts at ptr; lowest set bit wins.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                                input logic [ID_W-1:0]  ptr);
        logic [2*N_REQ-1:0] rot;
        int                 off;
        int                 sum;
        rot = {valid, valid} >> ptr;
        off = 0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot[j]) off = j;
        end
        sum = int'(ptr) + off;
        if (sum >= N_REQ) sum = sum - N_REQ;
        return ID_W'(sum);
    endfunction

    state_t              r_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [DATA_W-1:0]   r_op_in1;
    logic [DATA_W-1:0]   r_op_in2;
    logic [CTRL_W-1:0]   r_op_ctrl;
    logic [ID_W-1:0]     r_op_id;
    logic [ID_W-1:0]     r_rsp_id;
    logic [DATA_W-1:0]   r_rsp_out;
    logic                r_rsp_zero;
    logic                r_rsp_neg;

    logic [ID_W-1:0]     w_winner;
    logic                w_xfer;
    logic [DATA_W-1:0]   w_sel_in1;
    logic [DATA_W-1:0]   w_sel_in2;
    logic [CTRL_W-1:0]   w_sel_ctrl;
    logic [DATA_W-1:0]   w_alu_out;
    logic                w_alu_zero;
    logic                w_alu_neg;
    logic [ID_W-1:0]     w_rr_next;

    assign w_winner  = rr_pick(i_req_valid, r_rr_ptr);
    assign w_xfer    = (r_state == IDLE) && (|i_req_valid);
    assign w_rr_next = (r_rsp_id == ID_W'(N_REQ - 1)) ? '0 : r_rsp_id + 1'b1;

    always_comb begin
        o_req_ready = '0;
        w_sel_in1   = '0;
        w_sel_in2   = '0;
        w_sel_ctrl  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_winner == ID_W'(i)) begin
                o_req_ready[i] = w_xfer;
                w_sel_in1      = i_req_in1[i*DATA_W +: DATA_W];
                w_sel_in2      = i_req_in2[i*DATA_W +: DATA_W];
                w_sel_ctrl     = i_req_ctrl[i*CTRL_W +: CTRL_W];
            end
        end
    end

    // The alu only ever sees the captured operands, never the live request bus.
    alu_arbiter_alu #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_alu (
        .i_in1  (r_op_in1),
        .i_in2  (r_op_in2),
        .i_ctrl (r_op_ctrl),
        .o_out  (w_alu_out),
        .o_zero (w_alu_zero),
        .o_neg  (w_alu_neg)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_op_in1   <= '0;
            r_op_in2   <= '0;
            r_op_ctrl  <= '0;
            r_op_id    <= '0;
            r_rsp_id   <= '0;
            r_rsp_out  <= '0;
            r_rsp_zero <= 1'b0;
            r_rsp_neg  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_op_in1  <= w_sel_in1;
                        r_op_in2  <= w_sel_in2;
                        r_op_ctrl <= w_sel_ctrl;
                        r_op_id   <= w_winner;
                        r_state   <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_out  <= w_alu_out;
                    r_rsp_zero <= w_alu_zero;
                    r_rsp_neg  <= w_alu_neg;
                    r_rsp_id   <= r_op_id;
                    r_state    <= RESP;
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        r_rr_ptr <= w_rr_next;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_rsp_valid = (r_state == RESP);
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_out   = r_rsp_out;
    assign o_rsp_zero  = r_rsp_zero;
    assign o_rsp_neg   = r_rsp_neg;

`ifdef ALU_ARB_STATS_EN
    logic [N_REQ-1:0][STAT_W-1:0] r_stat;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stat <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_xfer && (w_winner == ID_W'(i))) r_stat[i] <= r_stat[i] + 1'b1;
            end
        end
    end

    assign o_stat_grants = r_stat;
`endif

endmodule
